wb_initiator_bridge: RTL
========================

Name: wb_initiator_bridge

Overview:
- Wishbone classic single-transfer initiator (master) clocked on wb_clk_i; the counterpart to the user area's Wishbone responder.
- Takes one command at a time over a valid/ready handshake (sourced from logic-analyzer bits or a local sequencer) and runs one classic cycle on a master port.
- Returns read data and completion status over a valid/ready response channel.
- Lets the user area exercise its own slaves, such as the example project, without the management SoC.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for ack/err before abort (only used with the optional feature); legal range 1..65535.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  bridge can accept a command.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data (0 for writes and errors).
- rsp_err_o  out  1  cycle ended by err or timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error.
- txn_count_o  out  CNT_W  completed transactions, including errored ones.

Behaviour:
- All outputs are registered except cmd_ready_o, which is decoded from state: cmd_ready_o = (state==IDLE).
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE.
  - All wbm_* outputs, rsp_valid_o, rsp_err_o, rsp_dat_o and txn_count_o = 0.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - On cmd_valid_i && cmd_ready_o at edge N, latch we/adr/dat/sel into the wbm_* registers.
  - Set wbm_cyc_o = wbm_stb_o = 1, visible from cycle N+1; go to BUS.
- BUS:
  - cyc/stb/we/adr/dat/sel are held stable until termination.
  - At the first edge M where wbm_ack_i || wbm_err_i:
    - drop cyc/stb (low from M+1);
    - set rsp_valid_o=1 from M+1;
    - rsp_err_o = wbm_err_i;
    - rsp_dat_o = wbm_dat_i if ack && !we && !err, else 0;
    - txn_count_o increments;
    - go to RSP.
  - ack and err asserted together: err wins (rsp_err_o=1, rsp_dat_o=0).
  - Minimum command-accept to response latency is 2 cycles (zero-wait-state slave acking in the first cycle stb is seen).
- RSP:
  - rsp_* are held stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i: rsp_valid_o=0 and go to IDLE.
  - The next command can be accepted the cycle after the response handshake; no overlap, no pipelining.
- Ack/err arriving outside BUS is ignored.
- txn_count_o wraps from 2^CNT_W-1 to 0 silently.
- cmd_valid_i while not ready: the command is not taken; the source must hold it.
- Reset mid-cycle (BUS or RSP): cyc/stb drop immediately (asynchronous), the pending response is discarded, and txn_count_o clears.

Optional Feature:
- Macro: WB_INITIATOR_BRIDGE_TIMEOUT_EN.
- Defined:
  - a 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack/err;
  - when it reaches TIMEOUT_CYCLES with no ack/err at that edge, the cycle aborts exactly like an err termination (rsp_err_o=1, rsp_dat_o=0, count increments);
  - ack/err at the expiry edge takes precedence over the timeout.
- Undefined: no counter; BUS waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package wb_pkg:
  - state enum (IDLE/BUS/RSP);
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - ERR_RDATA = 32'h0.
- Sub-module: no separate sub-module needed; the timeout counter is a small always block inside the macro guard.

Test Plan:
- Write, zero-wait slave: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF. Slave acks the first stb cycle. Required:
  - wbm_* match the command;
  - cyc high exactly 1 cycle;
  - rsp_valid 2 cycles after accept, with rsp_err=0 and rsp_dat=0;
  - txn_count=1.
- Read with 3 wait states, slave returns 0xCAFE_F00D: cyc/stb high 4 cycles, rsp_dat=0xCAFE_F00D, rsp_err=0.
- Backpressure: rsp_ready low for 5 cycles after response. Required:
  - rsp_valid/rsp_dat stable throughout;
  - cmd_ready low throughout;
  - a second cmd_valid is not accepted until the cycle after the rsp handshake.
- Simultaneous ack+err on a read returning 0x1111_1111: rsp_err=1, rsp_dat=0.
- With WB_INITIATOR_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks. Required:
  - cyc drops after 8 BUS cycles;
  - rsp_err=1;
  - txn_count increments.
  - Variant: ack on the 8th cycle yields rsp_err=0.
- Assert wb_rst_i during BUS: cyc/stb/rsp_valid go 0 asynchronously and txn_count=0. After release, a fresh read completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone initiator bridge
package wb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   localparam logic [WB_DAT_W-1:0] ERR_RDATA = 32'h0;
endpackage

// File: rtl/wb_initiator_bridge.sv
// rtl/wb_initiator_bridge.sv - Wishbone classic single-transfer initiator with valid/ready cmd/rsp
// Optional bus watchdog: define WB_INITIATOR_BRIDGE_TIMEOUT_EN to abort cycles after TIMEOUT_CYCLES.
module wb_initiator_bridge
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [WB_ADR_W-1:0] cmd_adr_i,
   input  logic [WB_DAT_W-1:0] cmd_dat_i,
   input  logic [WB_SEL_W-1:0] cmd_sel_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [WB_DAT_W-1:0] rsp_dat_o,
   output logic                rsp_err_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [WB_SEL_W-1:0] wbm_sel_o,
   output logic [WB_ADR_W-1:0] wbm_adr_o,
   output logic [WB_DAT_W-1:0] wbm_dat_o,
   input  logic [WB_DAT_W-1:0] wbm_dat_i,
   input  logic                wbm_ack_i,
   input  logic                wbm_err_i,
   output logic [CNT_W-1:0]    txn_count_o
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   state_t state;
   logic   timeout_hit;

   assign cmd_ready_o = (state == IDLE);

`ifdef WB_INITIATOR_BRIDGE_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt;

   // wait_cnt holds the number of BUS cycles already elapsed without termination
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wait_cnt <= 16'd0;
      end else if (state == BUS && !(wbm_ack_i || wbm_err_i)) begin
         wait_cnt <= wait_cnt + 16'd1;
      end else if (state != BUS) begin
         wait_cnt <= 16'd0;
      end
   end

   assign timeout_hit = (state == BUS) && (wait_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= '0;
         txn_count_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  wbm_we_o  <= cmd_we_i;
                  wbm_adr_o <= cmd_adr_i;
                  wbm_dat_o <= cmd_dat_i;
                  wbm_sel_o <= cmd_sel_i;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  state     <= BUS;
               end
            end
            BUS: begin
               // err beats ack; the watchdog only fires when the slave stays silent
               if (wbm_ack_i || wbm_err_i || timeout_hit) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= wbm_err_i || !wbm_ack_i;
                  rsp_dat_o   <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : ERR_RDATA;
                  txn_count_o <= txn_count_o + 1'b1;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
